// File: rtl/uart_tx_fifo.sv
// Transmit-side word queue for the UART: first-word-fall-through circular
// buffer with occupancy count and a sticky overflow flag.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             WriteStrobe,
    input  logic [WIDTH-1:0] WrData,
    input  logic             ReadStrobe,
    input  logic             Flush,
    input  logic             ClearOverflow,
    output logic [WIDTH-1:0] RdData,
    output logic             Empty,
    output logic             Full,
    output logic [CW-1:0]    Count,
    output logic             Overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             empty_q;
    logic             full_q;
    logic             ovf_q;

    logic pop_ok;
    logic push_ok;
    logic drop;

    // A pop in the same cycle frees the slot a full-queue push needs.
    assign pop_ok  = ReadStrobe && !empty_q;
    assign push_ok = WriteStrobe && (!full_q || pop_ok);
    assign drop    = WriteStrobe && !push_ok;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (Flush) begin
                wptr    <= '0;
                rptr    <= '0;
                count   <= '0;
                empty_q <= 1'b1;
                full_q  <= 1'b0;
            end else begin
                if (push_ok)
                    wptr <= wptr + 1'b1;
                if (pop_ok)
                    rptr <= rptr + 1'b1;
                case ({push_ok, pop_ok})
                    2'b10: begin
                        count   <= count + 1'b1;
                        empty_q <= 1'b0;
                        full_q  <= (count == CW'(DEPTH - 1));
                    end
                    2'b01: begin
                        count   <= count - 1'b1;
                        empty_q <= (count == CW'(1));
                        full_q  <= 1'b0;
                    end
                    default: begin
                        count   <= count;
                        empty_q <= empty_q;
                        full_q  <= full_q;
                    end
                endcase
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)
                ovf_q <= 1'b1;
            else if (ClearOverflow)
                ovf_q <= 1'b0;
        end
    end

    // Storage carries no reset; stale words are never visible while empty.
    always_ff @(posedge Clock) begin
        if (Reset && !Flush && push_ok)
            mem[wptr] <= WrData;
    end

    assign RdData   = mem[rptr];
    assign Empty    = empty_q;
    assign Full     = full_q;
    assign Count    = count;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: vector table plus hand-written
// sequences for fill/overflow, full-queue push+pop, wrap, flush and reset.
module tb_uart_tx_fifo;

    logic       Clock;
    logic       Reset;
    logic       WriteStrobe;
    logic [7:0] WrData;
    logic       ReadStrobe;
    logic       Flush;
    logic       ClearOverflow;
    logic [7:0] RdData;
    logic       Empty;
    logic       Full;
    logic [4:0] Count;
    logic       Overflow;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(.WIDTH(8), .DEPTH(16)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .WriteStrobe(WriteStrobe),
        .WrData(WrData),
        .ReadStrobe(ReadStrobe),
        .Flush(Flush),
        .ClearOverflow(ClearOverflow),
        .RdData(RdData),
        .Empty(Empty),
        .Full(Full),
        .Count(Count),
        .Overflow(Overflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic       rst_n;
        logic       ws;
        logic [7:0] wd;
        logic       rs;
        logic       fl;
        logic       co;
        int         cnt;
        logic       emp;
        logic       ful;
        logic       ovf;
        logic       chkrd;
        logic [7:0] rd;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic rst_n, input logic ws, input logic [7:0] wd,
                       input logic rs, input logic fl, input logic co);
        @(negedge Clock);
        Reset         = rst_n;
        WriteStrobe   = ws;
        WrData        = wd;
        ReadStrobe    = rs;
        Flush         = fl;
        ClearOverflow = co;
        @(posedge Clock);
        #1;
    endtask

    task automatic st(input string nm, input int cnt, input logic emp,
                      input logic ful, input logic ovf);
        chk({nm, ".count"}, int'(Count), cnt);
        chk({nm, ".empty"}, int'(Empty), int'(emp));
        chk({nm, ".full"}, int'(Full), int'(ful));
        chk({nm, ".ovf"}, int'(Overflow), int'(ovf));
    endtask

    task automatic rd(input string nm, input logic [7:0] v);
        chk({nm, ".rd"}, int'(RdData), int'(v));
    endtask

    initial begin
        Reset = 1'b0;
        WriteStrobe = 1'b0;
        WrData = 8'h00;
        ReadStrobe = 1'b0;
        Flush = 1'b0;
        ClearOverflow = 1'b0;

        //          rst ws  wd     rs  fl  co  cnt emp ful ovf chk rd
        tbl[0] = '{1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
        tbl[2] = '{1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
        tbl[3] = '{1'b1, 1'b1, 8'h43, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'h41};
        tbl[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h42};
        tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h43};
        tbl[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[8] = '{1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77};
        tbl[9] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        st("reset", 0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].rst_n, tbl[i].ws, tbl[i].wd, tbl[i].rs, tbl[i].fl, tbl[i].co);
            st($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].emp, tbl[i].ful, tbl[i].ovf);
            if (tbl[i].chkrd)
                rd($sformatf("vec%0d", i), tbl[i].rd);
        end

        // Fill to 16, drop a 17th push, drain, clear overflow.
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            chk($sformatf("fill%0d.count", i), int'(Count), i + 1);
        end
        st("full", 16, 1'b0, 1'b1, 1'b0);
        rd("full", 8'h00);
        cyc(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        st("drop", 16, 1'b0, 1'b1, 1'b1);
        rd("drop", 8'h00);
        for (int i = 0; i < 16; i++) begin
            rd($sformatf("drain%0d", i), 8'(i));
            cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        st("drained", 0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        st("clrovf", 0, 1'b1, 1'b0, 1'b0);

        // Refill; drop together with clear keeps the flag set.
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'hAB, 1'b0, 1'b0, 1'b1);
        st("setwins", 16, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        st("clr2", 16, 1'b0, 1'b1, 1'b0);

        // Full with push+pop together: no drop, count unchanged.
        cyc(1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        st("fullpp", 16, 1'b0, 1'b1, 1'b0);
        rd("fullpp", 8'h01);
        for (int i = 1; i < 16; i++) begin
            rd($sformatf("dr55_%0d", i), 8'(i));
            cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        rd("last55", 8'h55);
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        st("dr55end", 0, 1'b1, 1'b0, 1'b0);

        // Wrap: 3 preloaded words, then 40 push+pop pairs.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            rd($sformatf("wrap%0d", i), 8'(8'h80 + i));
            cyc(1'b1, 1'b1, 8'(8'h83 + i), 1'b1, 1'b0, 1'b0);
            chk($sformatf("wrap%0d.count", i), int'(Count), 3);
        end
        for (int i = 40; i < 43; i++) begin
            rd($sformatf("wrapdr%0d", i), 8'(8'h80 + i));
            cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        st("wrapend", 0, 1'b1, 1'b0, 1'b0);

        // Count=5 with Overflow=1, then Flush with a push.
        for (int i = 0; i < 17; i++)
            cyc(1'b1, 1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++)
            cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        st("pre_flush", 5, 1'b0, 1'b0, 1'b1);
        rd("pre_flush", 8'h2B);
        cyc(1'b1, 1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
        st("flush", 0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
        rd("postflush", 8'h31);

        // Reset mid-stream, then a push on the first released edge.
        cyc(1'b1, 1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
        st("midrst", 0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        st("firstpush", 1, 1'b0, 1'b0, 1'b0);
        rd("firstpush", 8'h99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data word width in bits.
REQ-002 SHALL have parameter: DEPTH, 16, number of entries; power of two, minimum 2.
REQ-003 SHALL have parameter: CW, log2(DEPTH)+1, width of Count.
REQ-004 SHALL have port: Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port: Reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port: WriteStrobe  input  1  one-cycle push pulse, produced by the DATA-register write edge detector.
REQ-007 SHALL have port: WrData  input  WIDTH  word to push; sampled only when WriteStrobe=1.
REQ-008 SHALL have port: ReadStrobe  input  1  pop request from the UART transmitter.
REQ-009 SHALL have port: Flush  input  1  discard all stored entries.
REQ-010 SHALL have port: ClearOverflow  input  1  clear the Overflow flag.
REQ-011 SHALL have port: RdData  output  WIDTH  head-of-queue word (first-word-fall-through).
REQ-012 SHALL have port: Empty  output  1  no entries stored.
REQ-013 SHALL have port: Full  output  1  DEPTH entries stored.
REQ-014 SHALL have port: Count  output  CW  number of stored entries, 0..DEPTH.
REQ-015 SHALL have port: Overflow  output  1  sticky flag: a push was dropped.

Function
REQ-016 Storage SHALL be a circular buffer with write and read pointers of log2(DEPTH) bits; each pointer wraps from DEPTH-1 to 0.
REQ-017 Push SHALL be accepted when WriteStrobe=1 and (Full=0 or ReadStrobe accepted in the same cycle): WrData written at write pointer, write pointer +1.
REQ-018 Pop SHALL be accepted when ReadStrobe=1 and Empty=0: read pointer +1.
REQ-019 ReadStrobe while Empty=0 and WriteStrobe=1 at the same time SHALL perform both operations; Count is unchanged.
REQ-020 ReadStrobe while Empty=1 SHALL be ignored, including when WriteStrobe=1 in the same cycle; that push is still accepted.
REQ-021 WriteStrobe while Full=1 with no accepted pop SHALL be dropped, SHALL leave storage unchanged, and SHALL set Overflow=1 on the next edge.
REQ-022 Count SHALL update on the edge following an operation: +1 for push only, -1 for pop only, unchanged otherwise.
REQ-023 Empty SHALL equal (Count==0), and Full SHALL equal (Count==DEPTH), both registered-consistent with Count.
REQ-024 RdData SHALL equal the entry at the read pointer and is valid whenever Empty=0; its value while Empty=1 is don't-care.
REQ-025 Latency: a push at edge N SHALL make the word visible on RdData, with Empty=0, after edge N with zero added cycles.
REQ-026 Flush=1 SHALL, on the next edge, zero both pointers and Count, and SHALL override any push or pop in that cycle.
REQ-027 Flush SHALL NOT alter Overflow.
REQ-028 ClearOverflow=1 SHALL clear Overflow on the next edge, unless a push is dropped in the same cycle; in that case Overflow=1 (set wins).
REQ-029 Count SHALL never exceed DEPTH or go below 0 under any input combination.

Reset
REQ-030 Reset=0 at a rising edge SHALL set both pointers=0, Count=0, Empty=1, Full=0, Overflow=0, with priority over all other inputs.
REQ-031 Reset asserted mid-operation SHALL discard all contents; storage array contents need not be cleared.
REQ-032 The first edge with Reset=1 SHALL accept a push normally.

Verification
REQ-033 Reset, then push 0x41, 0x42, 0x43 -> Count=3; RdData=0x41; three pops yield 0x41, 0x42, 0x43; then Empty=1.
REQ-034 16 pushes of 0x00..0x0F -> Full=1, Count=16; a 17th push 0xAA is dropped and Overflow=1; draining returns 0x00..0x0F; ClearOverflow -> Overflow=0.
REQ-035 Full, then simultaneous push 0x55 with pop -> Count stays 16, Overflow=0; after draining, 0x55 is the last word out.
REQ-036 Empty, then simultaneous push 0x77 with pop -> Count=1, RdData=0x77.
REQ-037 Pointer wrap: 40 interleaved push/pop pairs with incrementing data -> output order is preserved across wrap, and Count never exceeds DEPTH.
REQ-038 With Count=5 and Overflow=1, Flush together with push -> Count=0, Empty=1, Overflow stays 1; Reset=0 mid-stream -> all outputs at reset values on the next edge.
